// File: rtl/lr35902_irq_if.sv
// CPU-side register bus and interrupt handshake of the LR35902 interrupt controller.
// Strobes and int_ack are single-cycle pulses sampled on the rising clock edge.
interface lr35902_irq_if;
    logic [7:0] reg_dout;
    logic [7:0] reg_din;
    logic [7:0] reg_adr;
    logic       reg_read;
    logic       reg_write;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_ack;

    modport master (
        input  reg_dout, int_req, int_vec,
        output reg_din, reg_adr, reg_read, reg_write, int_ack
    );

    modport slave (
        input  reg_din, reg_adr, reg_read, reg_write, int_ack,
        output reg_dout, int_req, int_vec
    );
endinterface

// File: rtl/lr35902_irq.sv
// LR35902 interrupt controller: edge-detected request flags (IF), enable register (IE),
// fixed-priority vector generation and acknowledge clearing.
module lr35902_irq (
    input  logic          clk,
    input  logic          reset_n,
    lr35902_irq_if.slave  bus,
    input  logic          irq_vblank,
    input  logic          irq_stat,
    input  logic          irq_timer,
    input  logic          irq_serial,
    input  logic          irq_joypad
);
    localparam logic [7:0] ADR_IF = 8'h0F;
    localparam logic [7:0] ADR_IE = 8'hFF;

    logic [4:0] if_reg;
    logic [7:0] ie_reg;
    logic [4:0] prev_lvl;
    logic [7:0] dout_reg;

    logic [4:0] src;
    logic [4:0] rise;
    logic [4:0] pending;
    logic [4:0] sel;
    logic [2:0] sel_idx;
    logic [4:0] if_next;

    assign src     = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
    assign rise    = src & ~prev_lvl;
    assign pending = if_reg & ie_reg[4:0];

    // Scan from lowest priority upward so the lowest pending index wins.
    always_comb begin
        sel     = 5'b00000;
        sel_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                sel     = 5'b00001 << i;
                sel_idx = 3'(i);
            end
        end
    end

    assign bus.int_req  = |pending;
    assign bus.int_vec  = bus.int_req ? (8'h40 + {2'b00, sel_idx, 3'b000}) : 8'h00;
    assign bus.reg_dout = dout_reg;

    // Write lands first, then the acknowledge clear, then new edges, so a fresh edge is never lost.
    always_comb begin
        if_next = if_reg;
        if (bus.reg_write && bus.reg_adr == ADR_IF)
            if_next = bus.reg_din[4:0];
        if (bus.int_ack && bus.int_req)
            if_next = if_next & ~sel;
        if_next = if_next | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_reg   <= 5'h00;
            ie_reg   <= 8'h00;
            prev_lvl <= 5'h00;
            dout_reg <= 8'hFF;
        end else begin
            if_reg   <= if_next;
            prev_lvl <= src;
            if (bus.reg_write && bus.reg_adr == ADR_IE)
                ie_reg <= bus.reg_din;
            if (bus.reg_read) begin
                if (bus.reg_adr == ADR_IF)
                    dout_reg <= {3'b111, if_reg};
                else if (bus.reg_adr == ADR_IE)
                    dout_reg <= ie_reg;
                else
                    dout_reg <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_lr35902_irq.sv
// Directed bench for lr35902_irq: register access, edge detection, priority,
// acknowledge ordering and asynchronous reset.
module tb_lr35902_irq;
    logic clk;
    logic reset_n;
    logic irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;
    int   n_vec;
    int   n_err;
    logic [7:0] rd;

    lr35902_irq_if bus ();

    lr35902_irq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .irq_vblank (irq_vblank),
        .irq_stat   (irq_stat),
        .irq_timer  (irq_timer),
        .irq_serial (irq_serial),
        .irq_joypad (irq_joypad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [7:0] data);
        bus.reg_adr   = adr;
        bus.reg_din   = data;
        bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] adr, output logic [7:0] data);
        bus.reg_adr  = adr;
        bus.reg_read = 1'b1;
        tick();
        bus.reg_read = 1'b0;
        data = bus.reg_dout;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        {irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad} = 5'b0;
        bus.reg_din = 8'h00; bus.reg_adr = 8'h00;
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.int_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", bus.reg_dout, 8'hFF);
        check("rst_req", bus.int_req, 1'b0);
        check("rst_vec", bus.int_vec, 8'h00);
        reset_n = 1'b1;
        bus_read(8'h0F, rd); check("rst_if", rd, 8'hE0);
        bus_read(8'hFF, rd); check("rst_ie", rd, 8'h00);

        // Single vblank pulse, then acknowledge
        bus_write(8'hFF, 8'h01);
        irq_vblank = 1'b1; tick(); irq_vblank = 1'b0;
        check("vbl_req", bus.int_req, 1'b1);
        check("vbl_vec", bus.int_vec, 8'h40);
        bus_read(8'h0F, rd); check("vbl_if", rd, 8'hE1);
        ack();
        check("vbl_ack_req", bus.int_req, 1'b0);
        bus_read(8'h0F, rd); check("vbl_ack_if", rd, 8'hE0);

        // Two sources together: priority and successive acks
        bus_write(8'hFF, 8'h1F);
        irq_stat = 1'b1; irq_joypad = 1'b1; tick();
        check("pri_vec0", bus.int_vec, 8'h48);
        ack();
        check("pri_vec1", bus.int_vec, 8'h60);
        check("pri_req1", bus.int_req, 1'b1);
        ack();
        check("pri_req2", bus.int_req, 1'b0);
        irq_stat = 1'b0; irq_joypad = 1'b0; tick();

        // Level held high must not re-trigger after IF is cleared
        irq_stat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) begin
                bus.reg_adr = 8'h0F; bus.reg_din = 8'h00; bus.reg_write = 1'b1;
            end else begin
                bus.reg_write = 1'b0;
            end
            tick();
        end
        bus.reg_write = 1'b0;
        bus_read(8'h0F, rd); check("hold_if", rd, 8'hE0);
        check("hold_req", bus.int_req, 1'b0);
        irq_stat = 1'b0; tick();
        irq_stat = 1'b1; tick();
        bus_read(8'h0F, rd); check("retrig_if", rd, 8'hE2);
        irq_stat = 1'b0;
        bus_write(8'h0F, 8'h00);

        // IF write concurrent with timer edge and a read of IF
        bus_write(8'h0F, 8'h1B);
        bus.reg_adr = 8'h0F; bus.reg_din = 8'h00;
        bus.reg_write = 1'b1; bus.reg_read = 1'b1; irq_timer = 1'b1;
        tick();
        bus.reg_write = 1'b0; bus.reg_read = 1'b0;
        check("wr_edge_rd_old", bus.reg_dout, 8'hFB);
        check("wr_edge_vec", bus.int_vec, 8'h50);
        bus_read(8'h0F, rd); check("wr_edge_if", rd, 8'hE4);
        irq_timer = 1'b0;
        bus_write(8'h0F, 8'h00);

        // Ack and a new edge on the same bit: the edge survives
        bus_write(8'h0F, 8'h01);
        irq_vblank = 1'b1; bus.int_ack = 1'b1; tick();
        bus.int_ack = 1'b0; irq_vblank = 1'b0;
        bus_read(8'h0F, rd); check("ack_edge_if", rd, 8'hE1);
        bus_write(8'h0F, 8'h00);

        // IE upper bits only: no request, ack ignored
        bus_write(8'hFF, 8'hE0);
        bus_read(8'hFF, rd); check("ie_hi_rd", rd, 8'hE0);
        bus_write(8'h0F, 8'h1F);
        check("ie_hi_req", bus.int_req, 1'b0);
        check("ie_hi_vec", bus.int_vec, 8'h00);
        ack();
        bus_read(8'h0F, rd); check("ie_hi_ack_if", rd, 8'hFF);

        // Unmapped address: writes ignored, reads return FF
        bus_write(8'h10, 8'h00);
        bus_read(8'hFF, rd); check("unmap_ie", rd, 8'hE0);
        bus_read(8'h05, rd); check("unmap_rd", rd, 8'hFF);
        bus_read(8'h0F, rd); check("unmap_if", rd, 8'hFF);

        // Asynchronous reset between edges
        bus_write(8'hFF, 8'h1F);
        check("pre_rst_req", bus.int_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_req", bus.int_req, 1'b0);
        check("async_vec", bus.int_vec, 8'h00);
        check("async_dout", bus.reg_dout, 8'hFF);
        #1;
        reset_n = 1'b1;
        bus_read(8'h0F, rd); check("post_rst_if", rd, 8'hE0);

        // Source already high at reset release counts as an edge
        @(negedge clk);
        reset_n = 1'b0;
        irq_serial = 1'b1;
        #2;
        reset_n = 1'b1;
        bus_read(8'h0F, rd); check("rel_edge_old", rd, 8'hE0);
        bus_read(8'h0F, rd); check("rel_edge_if", rd, 8'hE8);
        irq_serial = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lr35902_irq.md
LR35902_IRQ -- requirements
Module: lr35902_irq

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 reg_dout  out  8  registered read data.
REQ-005 reg_din  in  8  write data.
REQ-006 reg_adr  in  8  low byte of CPU I/O address; 'h0F = IF, 'hFF = IE.
REQ-007 reg_read  in  1  read strobe, one clk wide.
REQ-008 reg_write  in  1  write strobe, one clk wide.
REQ-009 irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad  in  1 each  source request levels, IF bits 0..4.
REQ-010 int_req  out  1  high while any IF bit with its matching IE bit set is pending.
REQ-011 int_vec  out  8  handler vector of the highest-priority pending source.
REQ-012 int_ack  in  1  one-clk CPU acknowledge of the vector currently on int_vec.

Function
REQ-013 SHALL hold IF[4:0] and IE[7:0] registers plus one previous-level flop per source.
REQ-014 SHALL detect a rising edge on a source when the current level is 1 and the previous-level flop is 0; previous-level flops update every clk.
REQ-015 A detected edge SHALL set the matching IF bit at the same clk edge on which it is detected; constant-high levels set nothing further.
REQ-016 Write to 'h0F SHALL load IF[4:0] from reg_din[4:0]; reg_din[7:5] are ignored.
REQ-017 Write to 'h FF SHALL load IE[7:0] from reg_din[7:0].
REQ-018 Writes to other addresses SHALL have no effect.
REQ-019 Read SHALL update reg_dout at the clk edge where reg_read is high: 'h0F -> {3'b111, IF}; 'hFF -> IE; others -> 'hFF; reg_dout holds its value otherwise.
REQ-020 A read concurrent with a write or edge SHALL return the pre-update register value.
REQ-021 pending = IF & IE[4:0]; int_req = |pending, combinational from registers.
REQ-022 Priority order: bit 0 (vblank) highest, bit 4 (joypad) lowest.
REQ-023 int_vec SHALL be 'h40 + 8*index of the lowest set pending bit: 'h40, 'h48, 'h50, 'h58, 'h60; 'h00 when nothing is pending.
REQ-024 int_ack while int_req is high SHALL clear only the IF bit selected by int_vec in that cycle; int_ack while int_req is low SHALL be ignored.
REQ-025 Same-cycle IF update SHALL be ordered as: IF write applies first, then ack clear, then edge set. A new edge therefore always survives.
REQ-026 IE[7:5] SHALL be stored and readable, and SHALL NOT affect int_req.
REQ-027 The block SHALL have no interrupt master enable; masking by IME is the CPU's job.

Reset
REQ-028 While reset_n is low: IF = 0, IE = 0, previous-level flops = 0, reg_dout = 'hFF, int_req = 0, int_vec = 'h00.
REQ-029 A source high at reset release SHALL count as a rising edge on the first clk edge and set its IF bit.
REQ-030 Reset asserted mid-operation SHALL clear state immediately, without waiting for clk.

Verification
REQ-031 IE='h01, pulse irq_vblank for 1 clk -> IF='h01, int_req=1, int_vec='h40; int_ack -> IF='h00, int_req=0.
REQ-032 IE='h1F, raise irq_stat and irq_joypad in the same clk -> int_vec='h48; ack -> int_vec='h60; ack -> int_req=0.
REQ-033 Hold irq_stat high 100 clk, write IF='h00 at clk 10 -> IF bit 1 stays 0 (no re-trigger); drop then raise irq_stat -> bit 1 set.
REQ-034 Write IF='h00 in the same clk as an irq_timer rising edge -> IF='h04; read 'h0F -> reg_dout='hE4.
REQ-035 Write IE='hE0, read 'hFF -> 'hE0; IF='h1F -> int_req=0, int_vec='h00; int_ack ignored, IF unchanged.
REQ-036 Assert reset_n low asynchronously between clk edges with IF='h1F -> int_req falls before the next clk edge; read 'h0F after release -> 'hE0.
